// File: rtl/vdp_vram_arbiter.sv
// Purpose: arbitrates the single-port VDP VRAM between graphics DMA, sprite fetch and CPU.
// Latency: gfx data one cycle after the tick; sprite/CPU ack exactly two cycles after grant.
// Backpressure: gfx is never stalled; sprite/CPU wait in their req/ack handshakes, CPU bounded by a wait counter.
//
// Ports:
//   pxclk, reset                         clock, synchronous active-high reset
//   gfx_rd_tick, gfx_addr, gfx_dout      graphics DMA read strobe/address, read data
//   spr_req, spr_addr, spr_ack, spr_dout sprite read handshake and data register
//   cpu_req, cpu_we, cpu_addr, cpu_din,
//   cpu_ack, cpu_dout                    CPU read/write handshake and read data register
//   vram_en, vram_we, vram_addr,
//   vram_din, vram_dout                  VRAM macro interface (drive is combinational)
module vdp_vram_arbiter #(
    parameter int VRAM_SIZE       = 8 * 1024,
    parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE),
    parameter int CPU_MAX_WAIT    = 8
) (
    input  logic                       pxclk,
    input  logic                       reset,
    input  logic                       gfx_rd_tick,
    input  logic [VRAM_ADDR_WIDTH-1:0] gfx_addr,
    output logic [7:0]                 gfx_dout,
    input  logic                       spr_req,
    input  logic [VRAM_ADDR_WIDTH-1:0] spr_addr,
    output logic                       spr_ack,
    output logic [7:0]                 spr_dout,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]                 cpu_din,
    output logic                       cpu_ack,
    output logic [7:0]                 cpu_dout,
    output logic                       vram_en,
    output logic                       vram_we,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_addr,
    output logic [7:0]                 vram_din,
    input  logic [7:0]                 vram_dout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_ACK     = 2'd2
    } rq_state_t;

    localparam logic [7:0] WAIT_THRESH = 8'(CPU_MAX_WAIT);

    rq_state_t  spr_st_q, spr_st_d;
    rq_state_t  cpu_st_q, cpu_st_d;
    logic [7:0] wait_q, wait_d;
    logic       cpu_we_q, cpu_we_d;
    logic       spr_ack_q, spr_ack_d;
    logic       cpu_ack_q, cpu_ack_d;
    logic [7:0] spr_dout_q, spr_dout_d;
    logic [7:0] cpu_dout_q, cpu_dout_d;

    logic spr_elig, cpu_elig, cpu_urgent;
    logic gnt_spr, gnt_cpu;

    // A requester is only eligible in IDLE, so it can never be granted
    // twice for the same handshake even while req stays high.
    assign spr_elig   = spr_req && (spr_st_q == ST_IDLE);
    assign cpu_elig   = cpu_req && (cpu_st_q == ST_IDLE);
    assign cpu_urgent = cpu_elig && (wait_q >= WAIT_THRESH);

    assign gnt_cpu = !gfx_rd_tick && (cpu_urgent || (cpu_elig && !spr_elig));
    assign gnt_spr = !gfx_rd_tick && !cpu_urgent && spr_elig;

    assign vram_en   = !reset && (gfx_rd_tick || gnt_spr || gnt_cpu);
    assign vram_we   = !reset && gnt_cpu && cpu_we;
    assign vram_addr = gfx_rd_tick ? gfx_addr : (gnt_cpu ? cpu_addr : spr_addr);
    assign vram_din  = cpu_din;

    assign gfx_dout = vram_dout;
    assign spr_ack  = spr_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign spr_dout = spr_dout_q;
    assign cpu_dout = cpu_dout_q;

    always_comb begin
        spr_st_d   = spr_st_q;
        cpu_st_d   = cpu_st_q;
        cpu_we_d   = cpu_we_q;
        spr_ack_d  = 1'b0;
        cpu_ack_d  = 1'b0;
        spr_dout_d = spr_dout_q;
        cpu_dout_d = cpu_dout_q;
        wait_d     = wait_q;

        case (spr_st_q)
            ST_IDLE:    if (gnt_spr) spr_st_d = ST_GRANTED;
            ST_GRANTED: begin
                // VRAM data for the grant cycle is valid now.
                spr_dout_d = vram_dout;
                spr_ack_d  = 1'b1;
                spr_st_d   = ST_ACK;
            end
            default:    spr_st_d = ST_IDLE;
        endcase

        case (cpu_st_q)
            ST_IDLE: begin
                if (gnt_cpu) begin
                    cpu_st_d = ST_GRANTED;
                    cpu_we_d = cpu_we;
                end
            end
            ST_GRANTED: begin
                if (!cpu_we_q) cpu_dout_d = vram_dout;
                cpu_ack_d = 1'b1;
                cpu_st_d  = ST_ACK;
            end
            default: cpu_st_d = ST_IDLE;
        endcase

        if (gnt_cpu) begin
            wait_d = 8'd0;
        end else if ((cpu_st_q == ST_IDLE) && !cpu_req) begin
            wait_d = 8'd0;
        end else if (cpu_elig && (wait_q != 8'hFF)) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge pxclk) begin
        if (reset) begin
            spr_st_q   <= ST_IDLE;
            cpu_st_q   <= ST_IDLE;
            cpu_we_q   <= 1'b0;
            spr_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            spr_dout_q <= 8'd0;
            cpu_dout_q <= 8'd0;
            wait_q     <= 8'd0;
        end else begin
            spr_st_q   <= spr_st_d;
            cpu_st_q   <= cpu_st_d;
            cpu_we_q   <= cpu_we_d;
            spr_ack_q  <= spr_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            spr_dout_q <= spr_dout_d;
            cpu_dout_q <= cpu_dout_d;
            wait_q     <= wait_d;
        end
    end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Purpose: directed self-checking bench for vdp_vram_arbiter with a write-first VRAM model.
// Latency: inputs driven 1 time unit after pxclk rise, outputs sampled 1 unit after that.
// Backpressure: sprite/CPU handshakes driven cycle by cycle from hand-computed schedules.
module tb_vdp_vram_arbiter;

    localparam int AW = 13;

    logic          pxclk = 1'b0;
    logic          reset;
    logic          gfx_rd_tick;
    logic [AW-1:0] gfx_addr;
    logic [7:0]    gfx_dout;
    logic          spr_req;
    logic [AW-1:0] spr_addr;
    logic          spr_ack;
    logic [7:0]    spr_dout;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_ack;
    logic [7:0]    cpu_dout;
    logic          vram_en;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_din;
    logic [7:0]    vram_dout;

    logic          mem_init;
    logic [7:0]    mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    vdp_vram_arbiter #(.CPU_MAX_WAIT(8)) dut (
        .pxclk(pxclk), .reset(reset),
        .gfx_rd_tick(gfx_rd_tick), .gfx_addr(gfx_addr), .gfx_dout(gfx_dout),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_dout(spr_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_din(vram_din), .vram_dout(vram_dout)
    );

    always #20 pxclk = ~pxclk;

    // Write-first synchronous VRAM; unwritten bytes hold addr[7:0]^8'h5A.
    always @(posedge pxclk) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (vram_en) begin
            if (vram_we) begin
                mem[vram_addr] <= vram_din;
                vram_dout      <= vram_din;
            end else begin
                vram_dout <= mem[vram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pxclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        gfx_rd_tick = 1'b0; gfx_addr = '0;
        spr_req = 1'b0; spr_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = 8'h00;

        // ---- Reset: VRAM drive forced off even with a tick present ----
        step(); step();
        mem_init = 1'b0;
        gfx_rd_tick = 1'b1; gfx_addr = 13'h0005; settle();
        chk("rst_en_forced", {15'd0, vram_en}, 16'd0);
        chk("rst_we_forced", {15'd0, vram_we}, 16'd0);
        step();
        gfx_rd_tick = 1'b0; reset = 1'b0;

        // ---- Idle after reset for 10 cycles ----
        for (int k = 0; k < 10; k++) begin
            step(); settle();
            chk("idle_en", {15'd0, vram_en}, 16'd0);
            chk("idle_acks", {14'd0, spr_ack, cpu_ack}, 16'd0);
            chk("idle_douts", {spr_dout, cpu_dout}, 16'h0000);
        end

        // ---- CPU write 0x0123 <= 0xA5 ----
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_din = 8'hA5; settle();
        chk("wr_g_en", {15'd0, vram_en}, 16'd1);
        chk("wr_g_we", {15'd0, vram_we}, 16'd1);
        chk("wr_g_addr", 16'(vram_addr), 16'h0123);
        chk("wr_g_din", {8'd0, vram_din}, 16'h00A5);
        step(); settle();                                   // g+1
        chk("wr_g1_we", {15'd0, vram_we}, 16'd0);
        chk("wr_g1_en", {15'd0, vram_en}, 16'd0);
        chk("wr_g1_ack", {15'd0, cpu_ack}, 16'd0);
        step(); settle();                                   // g+2
        chk("wr_g2_ack", {15'd0, cpu_ack}, 16'd1);
        chk("wr_g2_we", {15'd0, vram_we}, 16'd0);
        chk("wr_dout_kept", {8'd0, cpu_dout}, 16'h0000);
        cpu_req = 1'b0;
        step(); settle();                                   // g+3
        chk("wr_g3_ack", {15'd0, cpu_ack}, 16'd0);

        // ---- CPU read 0x0123 back ----
        cpu_req = 1'b1; cpu_we = 1'b0; settle();
        chk("rd_g_en", {15'd0, vram_en}, 16'd1);
        chk("rd_g_we", {15'd0, vram_we}, 16'd0);
        chk("rd_g_addr", 16'(vram_addr), 16'h0123);
        step(); settle();
        chk("rd_g1_ack", {15'd0, cpu_ack}, 16'd0);
        step(); settle();
        chk("rd_g2_ack", {15'd0, cpu_ack}, 16'd1);
        chk("rd_dout", {8'd0, cpu_dout}, 16'h00A5);
        cpu_req = 1'b0;
        step(); step();

        // ---- gfx tick every other cycle, CPU write 0x3C to 0x0200 pending ----
        gfx_rd_tick = 1'b1; gfx_addr = 13'h0010;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_din = 8'h3C; settle();
        chk("gx0_addr", 16'(vram_addr), 16'h0010);
        chk("gx0_we_deferred", {15'd0, vram_we}, 16'd0);
        chk("gx0_en", {15'd0, vram_en}, 16'd1);
        step(); gfx_rd_tick = 1'b0; settle();               // c1: CPU granted
        chk("gx1_gfx_dout", {8'd0, gfx_dout}, 16'h004A);
        chk("gx1_cpu_we", {15'd0, vram_we}, 16'd1);
        chk("gx1_cpu_addr", 16'(vram_addr), 16'h0200);
        step(); gfx_rd_tick = 1'b1; gfx_addr = 13'h0011; settle();
        chk("gx2_addr", 16'(vram_addr), 16'h0011);
        chk("gx2_we", {15'd0, vram_we}, 16'd0);
        step(); gfx_rd_tick = 1'b0; settle();
        chk("gx3_gfx_dout", {8'd0, gfx_dout}, 16'h004B);
        chk("gx3_cpu_ack", {15'd0, cpu_ack}, 16'd1);
        cpu_req = 1'b0;
        step(); gfx_rd_tick = 1'b1; gfx_addr = 13'h0200; settle();
        chk("gx4_addr", 16'(vram_addr), 16'h0200);
        step(); gfx_rd_tick = 1'b0; settle();
        chk("gx5_written", {8'd0, gfx_dout}, 16'h003C);
        step(); step();

        // ---- Sprite hog vs CPU wait counter (threshold 8) ----
        spr_req = 1'b1; spr_addr = 13'h0456;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
        gfx_rd_tick = 1'b1; gfx_addr = 13'h0020;
        for (int k = 0; k < 7; k++) begin                   // c0..c6: wait grows to 7
            settle();
            chk("hog_tick_addr", 16'(vram_addr), 16'h0020);
            step();
        end
        gfx_rd_tick = 1'b0; settle();                       // c7: wait=7, sprite wins
        chk("hog_c7_spr", 16'(vram_addr), 16'h0456);
        step(); gfx_rd_tick = 1'b1; settle();               // c8
        chk("hog_c8_gfx", 16'(vram_addr), 16'h0020);
        step(); settle();                                   // c9
        chk("hog_c9_spr_ack", {15'd0, spr_ack}, 16'd1);
        chk("hog_c9_spr_dout", {8'd0, spr_dout}, 16'h000C);
        step(); gfx_rd_tick = 1'b0; settle();               // c10: wait>=8, CPU outranks sprite
        chk("hog_c10_cpu", 16'(vram_addr), 16'h0123);
        chk("hog_c10_we", {15'd0, vram_we}, 16'd0);
        step(); settle();                                   // c11: sprite takes the free slot
        chk("hog_c11_spr", 16'(vram_addr), 16'h0456);
        step(); settle();                                   // c12
        chk("hog_c12_cpu_ack", {15'd0, cpu_ack}, 16'd1);
        chk("hog_c12_cpu_dout", {8'd0, cpu_dout}, 16'h00A5);
        chk("hog_c12_idle", {15'd0, vram_en}, 16'd0);
        step(); gfx_rd_tick = 1'b1; settle();               // c13: CPU re-requests, blocked by gfx
        chk("hog_c13_spr_ack", {15'd0, spr_ack}, 16'd1);
        step(); gfx_rd_tick = 1'b0; settle();               // c14: counter cleared -> sprite wins
        chk("hog_c14_spr", 16'(vram_addr), 16'h0456);
        step(); spr_req = 1'b0; cpu_req = 1'b0;
        step(); step(); step();

        // ---- Sprite and CPU in the same cycle, counter at 0 ----
        spr_req = 1'b1; spr_addr = 13'h0457;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0300; cpu_din = 8'h77; settle();
        chk("tie_g_spr", 16'(vram_addr), 16'h0457);
        chk("tie_g_we", {15'd0, vram_we}, 16'd0);
        step(); settle();
        chk("tie_g1_cpu", 16'(vram_addr), 16'h0300);
        chk("tie_g1_we", {15'd0, vram_we}, 16'd1);
        step(); settle();
        chk("tie_g2_spr_ack", {15'd0, spr_ack}, 16'd1);
        chk("tie_g2_spr_dout", {8'd0, spr_dout}, 16'h000D);
        spr_req = 1'b0;
        step(); settle();
        chk("tie_g3_cpu_ack", {15'd0, cpu_ack}, 16'd1);
        chk("tie_g3_spr_ack", {15'd0, spr_ack}, 16'd0);
        cpu_req = 1'b0;
        step(); step();

        // ---- Reset during GRANTED of a CPU read ----
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0300; settle();
        chk("rr_g_addr", 16'(vram_addr), 16'h0300);
        step();
        reset = 1'b1; cpu_req = 1'b0; gfx_rd_tick = 1'b1; settle();
        chk("rr_en_in_reset", {15'd0, vram_en}, 16'd0);
        step();
        reset = 1'b0; gfx_rd_tick = 1'b0; settle();
        chk("rr_no_ack", {15'd0, cpu_ack}, 16'd0);
        chk("rr_dout_cleared", {8'd0, cpu_dout}, 16'h0000);
        step(); settle();
        chk("rr_no_ack2", {15'd0, cpu_ack}, 16'd0);
        cpu_req = 1'b1; settle();
        chk("rr_regrant_en", {15'd0, vram_en}, 16'd1);
        chk("rr_regrant_addr", 16'(vram_addr), 16'h0300);
        step(); step(); settle();
        chk("rr_ack", {15'd0, cpu_ack}, 16'd1);
        chk("rr_dout", {8'd0, cpu_dout}, 16'h0077);
        cpu_req = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
